// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, LSB first, 1 stop) feeding a FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_BIT  = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [15:0] timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        sample_half;
    logic        sample_end;

    logic        push_req;
    logic        frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic        parity_bad;
    logic        parity_err_d;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          overrun_d;

    // rx_prev is a third stage used only for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign sample_half = (timer == HALF_BIT);
    assign sample_end  = (timer == LAST_TICK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_half) begin
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_end && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (sample_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame error outranks parity error; either one discards the byte
    always_comb begin
        push_req    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if ((state == STOP) && sample_end) begin
            if (!rx_sync) begin
                frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad) begin
                parity_err_d = 1'b1;
`endif
            end else begin
                push_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                end
                START: begin
                    timer <= sample_half ? '0 : timer + 16'd1;
                end
                DATA: begin
                    if (sample_end) begin
                        timer     <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_end) begin
                        timer      <= '0;
                        parity_bad <= (rx_sync != (^shift_reg));
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
`endif
                STOP: begin
                    timer <= sample_end ? '0 : timer + 16'd1;
                end
                default: timer <= '0;
            endcase
        end
    end

    assign full      = (count == DEPTH_CNT);
    assign rd_valid  = (count != '0);
    assign pop       = rd_valid && rd_ready;
    assign push_ok   = push_req && (!full || pop);
    assign overrun_d = push_req && full && !pop;

    // Storage is not reset; the head is masked to zero while empty
    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus randomized traffic
// against a frame-level queue model. Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected bytes in delivery order and expected pulse counts
    logic [7:0] q[$];
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    int seen_ferr = 0, seen_ovr = 0, seen_perr = 0;
    int unsigned valid_rise_cycle = 0;
    int ready_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rd_ready = 1'b0;
                1:       rd_ready = 1'b1;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (frame_err)  seen_ferr++;
            if (overrun)    seen_ovr++;
            if (parity_err) seen_perr++;
            if (prev_valid && !prev_ready) begin
                check("head_stable_valid", 32'(rd_valid), 32'd1);
                check("head_stable_data", 32'(rd_data), 32'(prev_data));
            end
            if (rd_valid && !prev_valid) valid_rise_cycle = cycle;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) check("spurious_pop", 32'(rd_data), 32'hFFFF_FFFF);
                else check("rd_data", 32'(rd_data), 32'(q.pop_front()));
            end
            prev_valid = rd_valid;
            prev_ready = rd_ready;
            prev_data  = rd_data;
        end
    end

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_flip, input int gap);
        if (!stop_bit)              exp_ferr++;
        else if (par_flip)          exp_perr++;
        else if (q.size() >= DEPTH) exp_ovr++;
        else                        q.push_back(b);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit((^b) ^ par_flip);
`endif
        hold_bit(stop_bit);
        rx = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_err"}, 32'(seen_ferr), 32'(exp_ferr));
        check({tag, "_overrun"}, 32'(seen_ovr), 32'(exp_ovr));
        check({tag, "_parity_err"}, 32'(seen_perr), 32'(exp_perr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0;
        int lat;
        logic [7:0] b;
        logic sb, pf;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single byte, latency bound from start edge
        ready_mode = 1;
        t0 = cycle;
        send_frame(8'h55, 1'b1, 1'b0, 6);
        lat = int'(valid_rise_cycle) - int'(t0);
        check("latency_in_bound", 32'((lat > 0) && (lat <= int'(FRAME_BITS * CPB + 4))), 32'd1);
        wait_drain("drain_55");
        check_counts("byte55");

        // Short low glitch must not start a frame; next frame still works
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_rd_valid", 32'(rd_valid), 32'd0);
        check_counts("glitch");
        send_frame(8'hE7, 1'b1, 1'b0, 6);
        wait_drain("drain_after_glitch");

        // Bad stop bit then good frame
        send_frame(8'hC3, 1'b0, 1'b0, 6);
        check("ferr_rd_valid", 32'(rd_valid), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 6);
        wait_drain("drain_3c");
        check_counts("frame_err");

`ifdef UART_RX_PARITY_EN
        send_frame(8'hA5, 1'b1, 1'b1, 6);
        check("perr_rd_valid", 32'(rd_valid), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0, 6);
        wait_drain("drain_a5");
        check_counts("parity");
`endif

        // Fill with consumer stalled: 16 accepted, 17th overruns
        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0, 4);
        check("full_rd_valid", 32'(rd_valid), 32'd1);
        check("full_head", 32'(rd_data), 32'h00);
        check_counts("before_overrun");
        send_frame(8'h10, 1'b1, 1'b0, 4);
        check_counts("after_overrun");
        ready_mode = 1;
        wait_drain("drain_full");
        check("drained_rd_valid", 32'(rd_valid), 32'd0);

        // Reset during data bit 4 of 0xFF with a byte still queued
        ready_mode = 0;
        send_frame(8'h5A, 1'b1, 1'b0, 4);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_reset_rd_valid", 32'(rd_valid), 32'd0);
        check("async_reset_rd_data", 32'(rd_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (CPB * 6) @(posedge clk);
        #1;
        check("post_reset_rd_valid", 32'(rd_valid), 32'd0);
        ready_mode = 1;
        send_frame(8'h81, 1'b1, 1'b0, 6);
        wait_drain("drain_81");
        check_counts("reset_mid_frame");

        // Randomized traffic with a random consumer
        ready_mode = 2;
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 9) != 0);
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(0, 4) == 0);
`else
            pf = 1'b0;
`endif
            send_frame(b, sb, pf, int'($urandom_range(4, 30)));
        end
        wait_drain("drain_random");
        check_counts("random");
        ready_mode = 1;
        repeat (4) @(posedge clk);
        #1;
        check("final_rd_valid", 32'(rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clk cycles per UART bit (12 MHz / 115200), legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, 2..256.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous, idle high.
REQ-006 SHALL have port rd_ready  input  1  consumer accepts head byte.
REQ-007 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port rd_data  output  8  FIFO head byte.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because FIFO full.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY (UART_RX_PARITY_EN only), STOP.
REQ-014 IDLE: falling edge of synchronized rx (1 then 0) -> START, bit timer cleared; a steady low level SHALL NOT retrigger.
REQ-015 START: sample at timer = CLKS_PER_BIT/2 (integer divide); sample 1 -> IDLE, glitch rejected, nothing reported; sample 0 -> DATA, timer cleared.
REQ-016 DATA: sample each time timer reaches CLKS_PER_BIT-1, then clear timer; shift 8 bits LSB first; after bit 7 -> PARITY or STOP.
REQ-017 STOP: sample at CLKS_PER_BIT-1; sample 1 with no parity error -> push byte; sample 0 -> frame_err pulse, byte discarded; always -> IDLE.
REQ-018 Frame error SHALL take precedence over parity error: only frame_err pulses when both occur.
REQ-019 Push SHALL make byte visible on rd_valid/rd_data the cycle after the stop sample; no same-cycle fall-through.
REQ-020 Pop SHALL occur on rising edge when rd_valid and rd_ready are both 1; rd_data SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-021 Push while full without simultaneous pop -> byte dropped, overrun pulse, FIFO contents unchanged.
REQ-022 Push while full with simultaneous pop SHALL be accepted; no overrun.
REQ-023 Push and pop on empty FIFO: push accepted, pop ignored (rd_valid=0 that cycle).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: FSM IDLE, timer 0, shift register 0, synchronizer flops 1, FIFO empty, rd_valid 0, rd_data 0, frame_err/overrun/parity_err 0.
REQ-026 Reset mid-frame SHALL abort the frame with no push or error pulse; after release, reception restarts only on a new falling edge.
REQ-027 Reset deassertion SHALL be consumed synchronously (no output change before first clk edge after release besides held reset values).

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: frame = start, 8 data, 1 even-parity bit sampled like a data bit, stop; mismatch with good stop -> parity_err pulse, byte discarded.
REQ-029 Macro UART_RX_PARITY_EN undefined: frame = start, 8 data, stop; PARITY state and parity logic absent; parity_err constant 0.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=16)
REQ-030 Send 0x55 with good stop, rd_ready=1 -> rd_valid single cycle, rd_data=0x55, within 10*16+4 cycles of start edge; no error pulses.
REQ-031 Drive rx low 4 cycles then high -> no rd_valid, no error pulse, FSM back in IDLE.
REQ-032 Send 0xC3 with stop bit 0 -> frame_err one pulse, rd_valid stays 0; following good 0x3C received correctly.
REQ-033 rd_ready=0, send 17 bytes 0x00..0x10 -> one overrun pulse on byte 0x10; then drain 16 reads -> 0x00..0x0F in order, rd_valid=0 after.
REQ-034 Assert rst_n=0 during data bit 4 of 0xFF, release, send 0x81 -> only 0x81 delivered, no error pulses.
REQ-035 With UART_RX_PARITY_EN: send 0xA5 with parity bit 1 (wrong) -> parity_err pulse, no data; with parity 0 -> 0xA5 delivered.
